// File: rtl/uart_time_reporter.sv
// Serialises a snapshot of the selected display time as "HH:MM:SS.CC\r\n" over UART 8N1.
// A frame starts on a request pulse or, when enabled, on every seconds change.
module uart_time_reporter #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       i_send,
  input  logic       i_auto_en,
  output logic       tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned BaudDiv = CLK_HZ / BAUD;
  localparam int unsigned CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BaudDiv - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic [5:0]      sec_prev_q;
  logic [6:0]      snap_msec_q;
  logic [5:0]      snap_sec_q, snap_min_q;
  logic [4:0]      snap_hour_q;
  logic            req, accept, bit_end;
  logic [15:0]     hour_asc, min_asc, sec_asc, msec_asc;
  logic [7:0]      cur_byte;

  // Saturate to 99 and return {tens, ones} as ASCII digits.
  function automatic logic [15:0] to_ascii(input logic [6:0] v);
    logic [6:0] sat;
    logic [6:0] tens, ones;
    sat  = (v > 7'd99) ? 7'd99 : v;
    tens = sat / 7'd10;
    ones = sat % 7'd10;
    return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, ones}};
  endfunction

  assign req      = i_send | (i_auto_en & (sec != sec_prev_q));
  assign bit_end  = (baud_cnt_q == CntLast);
  assign hour_asc = to_ascii({2'b00, snap_hour_q});
  assign min_asc  = to_ascii({1'b0, snap_min_q});
  assign sec_asc  = to_ascii({1'b0, snap_sec_q});
  assign msec_asc = to_ascii(snap_msec_q);

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx_q)
      4'd0:    cur_byte = hour_asc[15:8];
      4'd1:    cur_byte = hour_asc[7:0];
      4'd2:    cur_byte = 8'h3A;
      4'd3:    cur_byte = min_asc[15:8];
      4'd4:    cur_byte = min_asc[7:0];
      4'd5:    cur_byte = 8'h3A;
      4'd6:    cur_byte = sec_asc[15:8];
      4'd7:    cur_byte = sec_asc[7:0];
      4'd8:    cur_byte = 8'h2E;
      4'd9:    cur_byte = msec_asc[15:8];
      4'd10:   cur_byte = msec_asc[7:0];
      4'd11:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (req) begin
          accept     = 1'b1;
          state_d    = StStart;
          tx_d       = 1'b0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = StData;
          tx_d       = cur_byte[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          if (byte_idx_q == 4'd12) begin
            state_d    = StIdle;
            byte_idx_d = '0;
            done_d     = 1'b1;
          end else begin
            // Next byte's start bit follows the stop bit with no idle gap.
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = StStart;
            tx_d       = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      sec_prev_q  <= sec;
      snap_msec_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      sec_prev_q <= sec;
      if (accept) begin
        snap_msec_q <= msec;
        snap_sec_q  <= sec;
        snap_min_q  <= min;
        snap_hour_q <= hour;
      end
    end
  end

  assign tx     = tx_q;
  assign o_busy = (state_q != StIdle);
  assign o_done = done_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: cycle-exact waveform and decoded-byte checks against a
// frame model built from the time fields, with directed and randomized scenarios.
module tb_uart_time_reporter;

  typedef logic [7:0] frame_t [13];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic       i_send = 1'b0;
  logic       i_auto_en = 1'b0;
  logic       tx, o_busy, o_done;
  int         checks = 0;
  int         failures = 0;

  uart_time_reporter #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .i_send(i_send), .i_auto_en(i_auto_en), .tx(tx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  function automatic frame_t make_frame(input int h, input int m, input int s, input int c);
    frame_t f;
    int v[4];
    v[0] = h; v[1] = m; v[2] = s; v[3] = c;
    for (int i = 0; i < 4; i++) if (v[i] > 99) v[i] = 99;
    f[0] = 8'(48 + v[0] / 10); f[1] = 8'(48 + v[0] % 10); f[2] = ":";
    f[3] = 8'(48 + v[1] / 10); f[4] = 8'(48 + v[1] % 10); f[5] = ":";
    f[6] = 8'(48 + v[2] / 10); f[7] = 8'(48 + v[2] % 10); f[8] = ".";
    f[9] = 8'(48 + v[3] / 10); f[10] = 8'(48 + v[3] % 10);
    f[11] = 8'h0D; f[12] = 8'h0A;
    return f;
  endfunction

  // Entered at the negedge where the request is driven. kind: 0 plain, 1 change hour at
  // cycle 200, 2 extra i_send pulses at 50/400, 3 assert rst so it lands at cycle 640.
  task automatic watch_frame(input frame_t exp, input int kind, input logic [4:0] new_hour,
                             input string tag);
    int limit, bad_tx, first_bad, bad_busy, bad_done, b, p;
    logic exp_bit;
    frame_t rx;
    limit = (kind == 3) ? 640 : 1300;
    bad_tx = 0; first_bad = -1; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 13; i++) rx[i] = '0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (c == 0) i_send = 1'b0;
      b = c / 100;
      p = (c % 100) / 10;
      exp_bit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : exp[b][p-1];
      if (tx !== exp_bit) begin
        bad_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if (o_busy !== 1'b1) bad_busy++;
      if (o_done !== 1'b0) bad_done++;
      if (c % 10 == 5 && p >= 1 && p <= 8) rx[b][p-1] = tx;
      if (kind == 1 && c == 200) hour = new_hour;
      if (kind == 2 && (c == 50 || c == 400)) i_send = 1'b1;
      if (kind == 2 && (c == 51 || c == 401)) i_send = 1'b0;
      if (kind == 3 && c == 639) rst = 1'b1;
    end
    checks++;
    if (bad_tx !== 0) begin
      failures++;
      $display("FAIL %s tx_waveform: %0d wrong cycles (first at %0d), required 0", tag, bad_tx,
               first_bad);
    end
    checks++;
    if (bad_busy !== 0) begin
      failures++;
      $display("FAIL %s busy_during_frame: %0d low cycles, required 0", tag, bad_busy);
    end
    checks++;
    if (bad_done !== 0) begin
      failures++;
      $display("FAIL %s done_during_frame: %0d high cycles, required 0", tag, bad_done);
    end
    for (int i = 0; i < 13; i++) begin
      if (kind != 3 || i < 6) begin
        checks++;
        if (rx[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s byte%0d: got %h, required %h", tag, i, rx[i], exp[i]);
        end
      end
    end
    if (kind != 3) begin
      @(negedge clk);
      checks++;
      if ({tx, o_busy, o_done} !== 3'b101) begin
        failures++;
        $display("FAIL %s done_pulse at 1300: tx/busy/done=%b, required 101", tag,
                 {tx, o_busy, o_done});
      end
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if ({tx, o_busy, o_done} !== 3'b100) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s idle: %0d non-idle cycles, required 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, o_busy, o_done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_state: tx/busy/done=%b, required 100", {tx, o_busy, o_done});
    end
    rst = 1'b0;
    check_idle(20, "after_reset");
  endtask

  task automatic test_basic();
    hour = 5'd13; min = 6'd5; sec = 6'd9; msec = 7'd42;
    @(negedge clk);
    i_send = 1'b1;
    watch_frame(make_frame(13, 5, 9, 42), 0, '0, "basic");
    check_idle(10, "basic_tail");
  endtask

  task automatic test_snapshot();
    hour = 5'd13; min = 6'd5; sec = 6'd9; msec = 7'd42;
    @(negedge clk);
    i_send = 1'b1;
    watch_frame(make_frame(13, 5, 9, 42), 1, 5'd7, "snap_first");
    check_idle(5, "snap_gap");
    i_send = 1'b1;
    watch_frame(make_frame(7, 5, 9, 42), 0, '0, "snap_second");
  endtask

  task automatic test_busy_ignore();
    hour = 5'd21; min = 6'd34; sec = 6'd56; msec = 7'd78;
    @(negedge clk);
    i_send = 1'b1;
    watch_frame(make_frame(21, 34, 56, 78), 2, '0, "busy_ignore");
    check_idle(200, "busy_ignore_tail");
  endtask

  task automatic test_auto();
    i_auto_en = 1'b0;
    hour = 5'd1; min = 6'd2; sec = 6'd58; msec = 7'd3;
    check_idle(3, "auto_setup");
    i_auto_en = 1'b1;
    check_idle(3, "auto_armed");
    sec = 6'd59;
    i_send = 1'b1;
    watch_frame(make_frame(1, 2, 59, 3), 0, '0, "auto_and_send");
    check_idle(200, "auto_single");
    sec = 6'd0;
    watch_frame(make_frame(1, 2, 0, 3), 0, '0, "auto_only");
    check_idle(20, "auto_only_tail");
    i_auto_en = 1'b0;
    sec = 6'd17;
    check_idle(50, "auto_disabled");
  endtask

  task automatic test_reset_mid();
    hour = 5'd10; min = 6'd20; sec = 6'd30; msec = 7'd40;
    @(negedge clk);
    i_send = 1'b1;
    watch_frame(make_frame(10, 20, 30, 40), 3, '0, "reset_mid");
    @(negedge clk);
    checks++;
    if ({tx, o_busy, o_done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_state: tx/busy/done=%b, required 100", {tx, o_busy, o_done});
    end
    rst = 1'b0;
    check_idle(1400, "reset_mid_abandon");
    hour = 5'd23; min = 6'd59; sec = 6'd1; msec = 7'd99;
    i_send = 1'b1;
    watch_frame(make_frame(23, 59, 1, 99), 0, '0, "reset_recover");
  endtask

  task automatic test_back_to_back();
    hour = 5'd0; min = 6'd63; sec = 6'd63; msec = 7'd120;
    @(negedge clk);
    i_send = 1'b1;
    watch_frame(make_frame(0, 63, 63, 120), 0, '0, "saturate");
    // Request lands in the o_done cycle: the next frame must start on the following edge.
    msec = 7'd7;
    i_send = 1'b1;
    watch_frame(make_frame(0, 63, 63, 7), 0, '0, "back_to_back");
  endtask

  task automatic test_random();
    int h, m, s, c;
    for (int k = 0; k < 3; k++) begin
      h = int'($urandom_range(0, 23));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      c = int'($urandom_range(0, 127));
      hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      i_send = 1'b1;
      watch_frame(make_frame(h, m, s, c), 0, '0, "random");
    end
    check_idle(10, "random_tail");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_busy_ignore();
    test_auto();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
